core_mem_arbiter: RTL and testbench
===================================

// Module: core_mem_arbiter
// PURPOSE
//  Shares the single external memory port between the core's bus masters:
//  icache refill (req 0), dcache/LSU (req 1) and debug module (req 2, highest index).
//  Round-robin grant, one outstanding transaction, grant held until memory ack.
//  Sits between the caches and the SoC memory interface. Fetch (PC -> icache)
//  stalls on icache misses until this block completes the refill beat.
// PARAMETERS
//  N_REQ       3    number of requesters; index N_REQ-1 is the debug port
//  ADDR_W      64   address width
//  DATA_W      64   data width; strobe width is DATA_W/8
//  TIMEOUT_CYC 255  watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  i_clk        in   1               clock, all logic on posedge
//  i_reset      in   1               asynchronous, active-high reset
//  i_req        in   N_REQ           per-requester request, held until its o_ack
//  i_we         in   N_REQ           per-requester write enable
//  i_addr       in   N_REQ*ADDR_W    packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//  i_wdata      in   N_REQ*DATA_W    packed write data
//  i_strb       in   N_REQ*DATA_W/8  packed byte strobes
//  i_halted     in   1               core in debug halt: only debug requester may be granted
//  o_ack        out  N_REQ           one-cycle completion pulse to the granted requester
//  o_err        out  N_REQ           one-cycle error pulse, coincident with o_ack
//  o_rdata      out  DATA_W          read data, valid with o_ack
//  o_mem_req    out  1               memory request, held until i_mem_ack
//  o_mem_we     out  1               latched write enable
//  o_mem_addr   out  ADDR_W          latched address
//  o_mem_wdata  out  DATA_W          latched write data
//  o_mem_strb   out  DATA_W/8        latched strobes
//  i_mem_ack    in   1               memory completion, one cycle
//  i_mem_rdata  in   DATA_W          memory read data, valid with i_mem_ack
//  o_grant      out  N_REQ           one-hot current owner, for debug/perf counters
// BEHAVIOUR
//  - States: IDLE, BUSY.
//  - Reset, asynchronous: state=IDLE, rr_ptr=N_REQ-1, o_grant=0, o_mem_req=0, o_mem_*=0,
//    o_ack=0, o_err=0, o_rdata=0.
//  - Reset during BUSY abandons the transaction. The memory side must tolerate o_mem_req dropping.
//  - IDLE, eligible requests present: pick the first eligible index searching rr_ptr+1 upward,
//    wrapping modulo N_REQ.
//  - IDLE pick, next edge: latch that requester's we/addr/wdata/strb into o_mem_*,
//    set o_mem_req=1, set o_grant, rr_ptr=winner, state=BUSY. Latency is 1 cycle from req to o_mem_req.
//  - Eligibility: i_req[k] && (!i_halted || k==N_REQ-1). Eligibility is sampled only in IDLE.
//    A grant already in BUSY completes even if i_halted rises.
//  - BUSY: o_mem_* stay stable; arbiter ignores all i_req changes.
//  - BUSY && i_mem_ack, next edge: o_ack[g]=1 for one cycle, o_rdata=i_mem_rdata (registered),
//    o_mem_req=0, o_grant=0, state=IDLE. o_rdata holds its value until the next ack.
//  - Requester rule: drop i_req at the edge where o_ack is seen. The following IDLE cycle samples it low.
//  - Back-to-back: minimum one IDLE cycle between transactions (no bypass).
//    Peak rate is one transaction per (memory latency + 2) cycles.
//  - i_mem_ack while IDLE is ignored. No o_ack is generated.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - 8..16-bit watchdog counter clears on entering BUSY and increments each BUSY cycle.
//   - When count==TIMEOUT_CYC without i_mem_ack: o_ack[g]=1, o_err[g]=1, o_rdata=0,
//     o_mem_req=0, state=IDLE.
//   - A late i_mem_ack arriving after the timeout is ignored.
//  MEM_ARB_TIMEOUT_EN undefined: BUSY waits indefinitely; o_err tied 0; no counter.
// STRUCTURE
//  - Package WivDefines: mem_arb_state_t enum {ARB_IDLE, ARB_BUSY};
//    MEM_ARB_REQ_ICACHE=0, MEM_ARB_REQ_DCACHE=1, MEM_ARB_REQ_DEBUG=2.
//  - Sub-module core_rr_picker: combinational find-first-set rotated by rr_ptr.
//    Inputs: eligible mask and rr_ptr. Outputs: valid and index. Parameterised by N_REQ.
// TESTING
//  1. Only req0 high, addr 0x1000, ack after 3 cycles, rdata 0x13 -> o_mem_req at cycle 1;
//     o_ack=3'b001 one cycle; o_rdata=0x13.
//  2. req0,1,2 all held, repeated acks -> grant order 0,1,2,0 (rr_ptr reset to 2 so 0 first);
//     no requester starved.
//  3. i_halted=1, req0 and req2 high -> req2 granted; req0 not granted until i_halted=0.
//  4. BUSY on req1, i_reset pulsed asynchronously mid-wait -> o_mem_req=0 immediately, o_grant=0;
//     after release, req1 re-granted cleanly.
//  5. Write req1, we=1, strb=0x0F, wdata=0xDEADBEEF -> o_mem_* match exactly and are stable
//     through BUSY while i_addr changes.
//  6. MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no ack -> o_ack and o_err pulse on requester after
//     8 BUSY cycles; a later i_mem_ack is ignored.

Source files
------------

// File: rtl/core_mem_arbiter_pkg.sv
// Shared definitions for the core memory arbiter: FSM state encoding and
// fixed requester indices.
package WivDefines;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } mem_arb_state_t;

  localparam int MEM_ARB_REQ_ICACHE = 0;
  localparam int MEM_ARB_REQ_DCACHE = 1;
  localparam int MEM_ARB_REQ_DEBUG  = 2;

endpackage

// File: rtl/core_mem_arbiter_rr_picker.sv
// Round-robin picker: finds the first set bit of the eligible mask, starting
// one position above rr_ptr and wrapping modulo N_REQ. Purely combinational.
module core_rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      int k;
      k = (int'(rr_ptr_i) + off) % N_REQ;
      if (elig_i[k]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Core memory arbiter: shares one external memory port between icache refill,
// dcache/LSU and the debug module. Round-robin grant, one outstanding
// transaction, grant held until memory acknowledges.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a BUSY watchdog that
// completes a stuck transaction with o_err after TIMEOUT_CYC cycles.
module core_mem_arbiter
  import WivDefines::*;
#(
  parameter int N_REQ       = 3,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_we,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_wdata,
  input  logic [N_REQ*DATA_W/8-1:0] i_strb,
  input  logic                      i_halted,
  output logic [N_REQ-1:0]          o_ack,
  output logic [N_REQ-1:0]          o_err,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_wdata,
  output logic [DATA_W/8-1:0]       o_mem_strb,
  input  logic                      i_mem_ack,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  output logic [N_REQ-1:0]          o_grant
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [N_REQ-1:0] DEBUG_MASK = N_REQ'(1) << (N_REQ - 1);

  mem_arb_state_t      state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [N_REQ-1:0]    grant_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_strb_q;
  logic [N_REQ-1:0]    ack_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [N_REQ-1:0]    elig;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;

  // While halted only the debug requester (highest index) may be granted.
  always_comb begin
    elig = i_req;
    if (i_halted) elig = i_req & DEBUG_MASK;
  end

  core_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .elig_i   (elig),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] err_q;
  logic             timeout;

  // Fires in the last allowed BUSY cycle, so completion lands after exactly
  // TIMEOUT_CYC busy cycles.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  // Arbitration FSM with all outputs registered; ack/err are one-cycle pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= IDX_W'(N_REQ - 1);
      grant_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= '0;
`endif
    end else begin
      ack_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q <= '0;
`endif
      case (state_q)
        ARB_IDLE: begin
          // A stray memory ack here is ignored.
          if (pick_valid) begin
            mem_we_q    <= i_we[pick_idx];
            mem_addr_q  <= i_addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata_q <= i_wdata[pick_idx*DATA_W +: DATA_W];
            mem_strb_q  <= i_strb[pick_idx*STRB_W +: STRB_W];
            mem_req_q   <= 1'b1;
            grant_q     <= N_REQ'(1) << pick_idx;
            rr_ptr_q    <= pick_idx;
            state_q     <= ARB_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        ARB_BUSY: begin
          if (i_mem_ack) begin
            ack_q     <= grant_q;
            rdata_q   <= i_mem_rdata;
            mem_req_q <= 1'b0;
            grant_q   <= '0;
            state_q   <= ARB_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (timeout) begin
            ack_q     <= grant_q;
            err_q     <= grant_q;
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            grant_q   <= '0;
            state_q   <= ARB_IDLE;
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  assign o_err = err_q;
`else
  assign o_err = '0;
`endif

  assign o_ack       = ack_q;
  assign o_rdata     = rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_strb  = mem_strb_q;
  assign o_grant     = grant_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed testbench for core_mem_arbiter (3 requesters, 64-bit address/data).
module tb_core_mem_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic                      i_clk = 1'b0;
  logic                      i_reset = 1'b1;
  logic [N_REQ-1:0]          i_req = '0;
  logic [N_REQ-1:0]          i_we = '0;
  logic [N_REQ*ADDR_W-1:0]   i_addr = '0;
  logic [N_REQ*DATA_W-1:0]   i_wdata = '0;
  logic [N_REQ*DATA_W/8-1:0] i_strb = '0;
  logic                      i_halted = 1'b0;
  logic [N_REQ-1:0]          o_ack;
  logic [N_REQ-1:0]          o_err;
  logic [DATA_W-1:0]         o_rdata;
  logic                      o_mem_req;
  logic                      o_mem_we;
  logic [ADDR_W-1:0]         o_mem_addr;
  logic [DATA_W-1:0]         o_mem_wdata;
  logic [DATA_W/8-1:0]       o_mem_strb;
  logic                      i_mem_ack = 1'b0;
  logic [DATA_W-1:0]         i_mem_rdata = '0;
  logic [N_REQ-1:0]          o_grant;

  int n_cmp = 0;
  int n_bad = 0;

  core_mem_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_strb(i_strb), .i_halted(i_halted),
    .o_ack(o_ack), .o_err(o_err), .o_rdata(o_rdata), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_strb(o_mem_strb), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] st);
    i_we[k]               = we;
    i_addr[k*ADDR_W +: ADDR_W]  = a;
    i_wdata[k*DATA_W +: DATA_W] = wd;
    i_strb[k*8 +: 8]      = st;
    i_req[k]              = 1'b1;
  endtask

  // Drive a one-cycle memory ack; returns just after the edge where o_ack shows.
  task automatic mem_ack(input logic [63:0] rd);
    i_mem_ack   = 1'b1;
    i_mem_rdata = rd;
    tick();
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
  endtask

  task automatic pulse_reset();
    #2 i_reset = 1'b1;
    #2 i_reset = 1'b0;
    i_req = '0;
    i_halted = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got %b exp 0", o_mem_req); end
    n_cmp++; if (o_grant !== 3'b000) begin n_bad++; $display("FAIL rst_grant got %b exp 000", o_grant); end
    n_cmp++; if (o_ack !== 3'b000 || o_err !== 3'b000) begin n_bad++; $display("FAIL rst_ack_err got %b/%b exp 000/000", o_ack, o_err); end
    n_cmp++; if (o_rdata !== 64'h0 || o_mem_addr !== 64'h0) begin n_bad++; $display("FAIL rst_data got %h/%h exp 0/0", o_rdata, o_mem_addr); end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 64'h1000, 64'h0, 8'h00);
    tick();
    n_cmp++; if (o_mem_req !== 1'b1) begin n_bad++; $display("FAIL rd_mem_req got %b exp 1", o_mem_req); end
    n_cmp++; if (o_grant !== 3'b001) begin n_bad++; $display("FAIL rd_grant got %b exp 001", o_grant); end
    n_cmp++; if (o_mem_addr !== 64'h1000 || o_mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_addr got %h we %b exp 1000 we 0", o_mem_addr, o_mem_we); end
    tick();
    tick();
    mem_ack(64'h13);
    i_req[0] = 1'b0;
    n_cmp++; if (o_ack !== 3'b001) begin n_bad++; $display("FAIL rd_ack got %b exp 001", o_ack); end
    n_cmp++; if (o_rdata !== 64'h13) begin n_bad++; $display("FAIL rd_rdata got %h exp 13", o_rdata); end
    n_cmp++; if (o_mem_req !== 1'b0 || o_grant !== 3'b000) begin n_bad++; $display("FAIL rd_release got %b/%b exp 0/000", o_mem_req, o_grant); end
    tick();
    n_cmp++; if (o_ack !== 3'b000) begin n_bad++; $display("FAIL rd_ack_pulse got %b exp 000", o_ack); end
    n_cmp++; if (o_rdata !== 64'h13) begin n_bad++; $display("FAIL rd_rdata_hold got %h exp 13", o_rdata); end
    n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL rd_no_regrant got %b exp 0", o_mem_req); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    pulse_reset();
    set_req(0, 1'b0, 64'hA0, 64'h0, 8'h00);
    set_req(1, 1'b0, 64'hA1, 64'h0, 8'h00);
    set_req(2, 1'b0, 64'hA2, 64'h0, 8'h00);
    for (int t = 0; t < 4; t++) begin
      tick();
      n_cmp++; if (o_grant !== exp_g[t]) begin n_bad++; $display("FAIL rr_grant[%0d] got %b exp %b", t, o_grant, exp_g[t]); end
      tick();
      mem_ack(64'h100 + 64'(t));
      n_cmp++; if (o_ack !== exp_g[t]) begin n_bad++; $display("FAIL rr_ack[%0d] got %b exp %b", t, o_ack, exp_g[t]); end
    end
    i_req = '0;
    tick();
  endtask

  task automatic test_halted();
    pulse_reset();
    i_halted = 1'b1;
    set_req(0, 1'b0, 64'hB0, 64'h0, 8'h00);
    set_req(2, 1'b0, 64'hB2, 64'h0, 8'h00);
    tick();
    n_cmp++; if (o_grant !== 3'b100) begin n_bad++; $display("FAIL halt_grant got %b exp 100", o_grant); end
    n_cmp++; if (o_mem_addr !== 64'hB2) begin n_bad++; $display("FAIL halt_addr got %h exp b2", o_mem_addr); end
    mem_ack(64'h22);
    i_req[2] = 1'b0;
    n_cmp++; if (o_ack !== 3'b100) begin n_bad++; $display("FAIL halt_ack got %b exp 100", o_ack); end
    tick();
    tick();
    n_cmp++; if (o_mem_req !== 1'b0 || o_grant !== 3'b000) begin n_bad++; $display("FAIL halt_block got %b/%b exp 0/000", o_mem_req, o_grant); end
    i_halted = 1'b0;
    tick();
    n_cmp++; if (o_grant !== 3'b001) begin n_bad++; $display("FAIL unhalt_grant got %b exp 001", o_grant); end
    mem_ack(64'h0);
    i_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    set_req(1, 1'b0, 64'hC1, 64'h0, 8'h00);
    tick();
    n_cmp++; if (o_grant !== 3'b010) begin n_bad++; $display("FAIL rb_grant got %b exp 010", o_grant); end
    tick();
    #2 i_reset = 1'b1;
    #1;
    n_cmp++; if (o_mem_req !== 1'b0 || o_grant !== 3'b000) begin n_bad++; $display("FAIL rb_async got %b/%b exp 0/000", o_mem_req, o_grant); end
    #1 i_reset = 1'b0;
    tick();
    n_cmp++; if (o_grant !== 3'b010 || o_mem_req !== 1'b1) begin n_bad++; $display("FAIL rb_regrant got %b/%b exp 010/1", o_grant, o_mem_req); end
    n_cmp++; if (o_mem_addr !== 64'hC1) begin n_bad++; $display("FAIL rb_addr got %h exp c1", o_mem_addr); end
    mem_ack(64'h77);
    i_req[1] = 1'b0;
    n_cmp++; if (o_ack !== 3'b010 || o_rdata !== 64'h77) begin n_bad++; $display("FAIL rb_ack got %b/%h exp 010/77", o_ack, o_rdata); end
    tick();
  endtask

  task automatic test_write_stable();
    set_req(1, 1'b1, 64'h2000, 64'hDEADBEEF, 8'h0F);
    tick();
    n_cmp++; if (o_mem_we !== 1'b1 || o_mem_strb !== 8'h0F) begin n_bad++; $display("FAIL wr_we_strb got %b/%h exp 1/0f", o_mem_we, o_mem_strb); end
    n_cmp++; if (o_mem_addr !== 64'h2000 || o_mem_wdata !== 64'hDEADBEEF) begin n_bad++; $display("FAIL wr_addr_data got %h/%h exp 2000/deadbeef", o_mem_addr, o_mem_wdata); end
    i_addr[ADDR_W +: ADDR_W] = 64'h3000;
    i_wdata[DATA_W +: DATA_W] = 64'h1234;
    i_strb[8 +: 8] = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (o_mem_addr !== 64'h2000 || o_mem_wdata !== 64'hDEADBEEF || o_mem_strb !== 8'h0F) begin
        n_bad++; $display("FAIL wr_stable[%0d] got %h/%h/%h exp 2000/deadbeef/0f", c, o_mem_addr, o_mem_wdata, o_mem_strb); end
    end
    mem_ack(64'h0);
    i_req[1] = 1'b0;
    n_cmp++; if (o_ack !== 3'b010) begin n_bad++; $display("FAIL wr_ack got %b exp 010", o_ack); end
    tick();
    // A memory ack in IDLE must not produce an ack or touch read data.
    mem_ack(64'h5555);
    n_cmp++; if (o_ack !== 3'b000 || o_rdata !== 64'h0) begin n_bad++; $display("FAIL idle_ack got %b/%h exp 000/0", o_ack, o_rdata); end
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    set_req(0, 1'b0, 64'hD0, 64'h0, 8'h00);
    tick();
    for (int c = 0; c < TMO - 1; c++) begin
      tick();
      if (o_ack !== 3'b000) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL tmo_early got %0d early acks exp 0", early); end
    tick();
    n_cmp++; if (o_ack !== 3'b001 || o_err !== 3'b001) begin n_bad++; $display("FAIL tmo_pulse got %b/%b exp 001/001", o_ack, o_err); end
    n_cmp++; if (o_mem_req !== 1'b0 || o_rdata !== 64'h0) begin n_bad++; $display("FAIL tmo_release got %b/%h exp 0/0", o_mem_req, o_rdata); end
    i_req[0] = 1'b0;
    mem_ack(64'h99);
    n_cmp++; if (o_ack !== 3'b000 || o_err !== 3'b000) begin n_bad++; $display("FAIL tmo_late got %b/%b exp 000/000", o_ack, o_err); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_halted();
    test_reset_busy();
    test_write_stable();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
